// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   UART_DATA_BITS : payload bits per frame (8N1 framing)
//   clks_per_bit() : integer number of system clocks per serial bit
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clocks of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver, LSB first, mid-bit sampling.
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   rx        : raw serial line (idle high), asynchronous to clk
//   data      : last correctly framed byte, held until the next valid
//   valid     : one-cycle strobe when data updates
//   frame_err : one-cycle strobe when the stop bit is sampled low
//   busy      : high while a frame is in progress
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST      = 3'(UART_DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    sh_d        = sh_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = ST_START;
      end

      ST_START: begin
        if (clk_cnt_q == CNT_HALF_LAST) begin
          clk_cnt_d = '0;
          // A start bit that is no longer low at its centre is a glitch.
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == CNT_BIT_LAST) begin
          clk_cnt_d       = '0;
          sh_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (clk_cnt_q == CNT_BIT_LAST) begin
          clk_cnt_d = '0;
          // Leaving at the stop-bit centre leaves half a bit of margin to
          // catch a back-to-back start edge.
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      ST_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      sh_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      sh_q        <= sh_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLK_HZ=1 MHz, BAUD=100 kbit/s
// (10 clocks per bit). The serial line is driven by a behavioural 8N1
// transmitter; expected bytes and arrival cycles come from frame arithmetic.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned CPB    = CLK_HZ / BAUD;
  localparam int unsigned HALF   = CPB / 2;
  // Pad falls just after edge N: two synchronizer edges, then IDLE sees the
  // low level at edge N+3 (E). The stop sample edge is E+HALF+9*CPB and
  // valid is visible right after it.
  localparam int unsigned LAT    = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled away from the active edge.
  logic [7:0]  got_q[$];
  int unsigned got_t[$];
  int unsigned ferr_cnt = 0;
  int unsigned both_cnt = 0;

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(data);
      got_t.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) both_cnt++;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int unsigned fall);
    fall = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_bit);
  endtask

  // One good frame followed by a gap; expects exactly one valid with the
  // sent byte at the computed cycle and no framing error.
  task automatic good_frame(input string tag, input logic [7:0] b, input int unsigned gap);
    int unsigned n0, fe0, f;
    n0  = got_q.size();
    fe0 = ferr_cnt;
    send_frame(b, 1'b1, f);
    idle(gap);
    exp_data = b;
    check({tag, "_nvalid"}, got_q.size(), n0 + 1);
    if (got_q.size() > n0) begin
      check({tag, "_data"}, got_q[n0], b);
      check({tag, "_lat"}, got_t[n0], f + LAT);
    end
    check({tag, "_hold"}, data, exp_data);
    check({tag, "_ferr"}, ferr_cnt, fe0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int unsigned n0, fe0, f0, f1;
    logic [7:0]  b;

    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(2 * CPB);

    // Directed and random bytes with random idle gaps
    good_frame("b55", 8'h55, CPB);
    good_frame("bA5", 8'hA5, CPB);
    good_frame("b00", 8'h00, CPB);
    good_frame("bFF", 8'hFF, CPB);
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      good_frame("rnd", b, $urandom_range(2, 3 * CPB));
    end

    // Back-to-back frames, no idle bit
    n0 = got_q.size();
    send_frame(8'h3C, 1'b1, f0);
    send_frame(8'hC3, 1'b1, f1);
    idle(CPB);
    exp_data = 8'hC3;
    check("b2b_nvalid", got_q.size(), n0 + 2);
    if (got_q.size() >= n0 + 2) begin
      check("b2b_d0", got_q[n0], 8'h3C);
      check("b2b_d1", got_q[n0 + 1], 8'hC3);
      check("b2b_gap", got_t[n0 + 1] - got_t[n0], 10 * CPB);
    end

    // Start glitch: 3 low clocks
    n0  = got_q.size();
    fe0 = ferr_cnt;
    rx  = 1'b0;
    @(posedge clk); #1;
    check("gl_busy1", busy, 1'b0);
    @(posedge clk); #1;
    check("gl_busy2", busy, 1'b0);
    @(posedge clk); #1;
    check("gl_busy3", busy, 1'b1);
    rx = 1'b1;
    for (int k = 0; k < HALF + 3 && busy; k++) begin
      @(posedge clk); #1;
    end
    check("gl_busy_drop", busy, 1'b0);
    idle(2 * CPB);
    check("gl_nvalid", got_q.size(), n0);
    check("gl_ferr", ferr_cnt, fe0);
    check("gl_data", data, exp_data);

    // Framing error then break
    n0  = got_q.size();
    fe0 = ferr_cnt;
    send_frame(8'h81, 1'b0, f0);
    rx = 1'b0;
    repeat (50 * CPB) @(posedge clk);
    #1;
    check("brk_busy", busy, 1'b1);
    idle(2 * CPB);
    check("brk_ferr", ferr_cnt, fe0 + 1);
    check("brk_nvalid", got_q.size(), n0);
    check("brk_data", data, exp_data);
    check("brk_busy_end", busy, 1'b0);
    good_frame("after_brk", 8'h42, CPB);

    // Reset during data bit 4
    b   = 8'($urandom);
    rx  = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) bit_time(b[i]);
    rx = b[4];
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mrst_data", data, 8'h00);
    check("mrst_valid", valid, 1'b0);
    check("mrst_ferr", frame_err, 1'b0);
    check("mrst_busy", busy, 1'b0);
    rst_n    = 1'b1;
    exp_data = 8'h00;
    n0       = got_q.size();
    fe0      = ferr_cnt;
    idle(12 * CPB);
    check("mrst_nvalid", got_q.size(), n0);
    check("mrst_nferr", ferr_cnt, fe0);
    check("mrst_hold", data, 8'h00);
    good_frame("after_rst", 8'h99, CPB);

    check("excl", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first, and the receive-side counterpart of the team's UART transmitter in the hello_uart_echo design. It synchronizes the raw `rx` pin, qualifies the start bit at mid-bit, and samples each data bit and the stop bit at its centre. It then presents each received byte with a one-cycle `valid` strobe, and flags framing errors. In the echo top it feeds the transmitter's `data`/`start` inputs.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s. Derived values:
  - `CLKS_PER_BIT = CLK_HZ / BAUD` (integer divide; 434 at defaults).
  - `HALF_BIT = CLKS_PER_BIT / 2` (217 at defaults).
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `rx`, in, 1: raw serial line, asynchronous to `clk`. Idle level is 1.
- `data`, out, 8: last correctly framed byte. Held until the next `valid`.
- `valid`, out, 1: one-cycle pulse when `data` is updated.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled as 0.
- `busy`, out, 1: high while a frame is being received (state ≠ IDLE).

## Operation
- **Synchronizer**
  - Two flops produce `rx_s` from `rx`. Both flops reset to 1.
  - All decisions use `rx_s` only.
- **Counters**
  - `clk_cnt` is wide enough to hold `CLKS_PER_BIT-1`.
  - `bit_idx` is 3 bits.
  - Shift register `sh` is 8 bits.
- **IDLE**
  - Outputs: `busy`=0; `clk_cnt` and `bit_idx` are cleared.
  - If `rx_s`==0, go to START with `clk_cnt`=0.
- **START**
  - Count until `clk_cnt`==`HALF_BIT-1`, then sample `rx_s`.
  - If `rx_s`==0: go to DATA with `clk_cnt`=0.
  - If `rx_s`==1: this is a glitch. Return to IDLE with no output pulse.
- **DATA**
  - Count until `clk_cnt`==`CLKS_PER_BIT-1`, then:
    - `sh[bit_idx]` <= `rx_s`;
    - `clk_cnt`=0;
    - if `bit_idx`==7, go to STOP with `bit_idx`=0; otherwise increment `bit_idx`.
- **STOP**
  - Count until `clk_cnt`==`CLKS_PER_BIT-1`, then sample `rx_s`.
  - If `rx_s`==1:
    - `data` <= `sh`, `valid`=1 for one cycle;
    - go to IDLE immediately at the stop-bit centre, so a start bit arriving half a bit later is caught.
  - If `rx_s`==0:
    - `frame_err`=1 for one cycle;
    - `data` is unchanged;
    - go to BREAK.
- **BREAK**
  - Wait for `rx_s`==1, then go to IDLE.
  - A line held low (break condition) produces exactly one `frame_err` and no further frames.
- **Illegal state**: return to IDLE.
- `valid` and `frame_err` are never high in the same cycle.
- There is no flow control. A byte overwrites `data` whether or not the consumer has read the previous one.

## Timing
- **Reset values**:
  - `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0;
  - state=IDLE, `rx_s`=1.
- **Start detection edge E**: the first edge at which IDLE sees `rx_s`==0. This is 2–3 clocks after the pad falling edge.
- **Sample points** (relative to E):
  - start qualification at E+`HALF_BIT`;
  - data bit i (i=0..7) at E+`HALF_BIT`+(i+1)·`CLKS_PER_BIT`;
  - stop bit at E+`HALF_BIT`+9·`CLKS_PER_BIT`.
- **Output pulses**: `valid`/`frame_err` are high in the cycle immediately after the stop sample edge. `data` changes on that same edge.
- **busy**:
  - high from E+1;
  - low again in the cycle after the stop sample (good frame) or after BREAK exits.
- **Back-to-back frames**: zero idle time between frames is supported.
- **Reset mid-frame**: the frame is discarded and no pulse is produced. If the line is low at reset release, the receiver re-qualifies it as a start bit. The resulting garbage frame ends in `frame_err` unless its stop bit happens to be high.
- **Tolerance**: mid-bit sampling tolerates ±4% combined baud mismatch.

## Structure
- **Shared package `uart_pkg`**:
  - constant `UART_DATA_BITS`=8;
  - function `clks_per_bit(clk_hz, baud)`;
  - both uart_tx and uart_rx use it.
- **State typedef**: stays local to `uart_rx` (IDLE, START, DATA, STOP, BREAK; 3-bit encoding).
- **Sub-module `sync_2ff`**:
  - parameter `RESET_VAL`;
  - ports `clk`, `rst_n`, `d`, `q`;
  - reusable for other asynchronous inputs.

## Test plan
1. **Loopback bytes**:
   - Stimulus: loopback from uart_tx, `CLK_HZ`=1_000_000, `BAUD`=100_000 (`CLKS_PER_BIT`=10); send 8'h55, 8'hA5, 8'h00, 8'hFF.
   - Required response: four `valid` pulses with matching `data`, and `frame_err` never asserted.
2. **Back-to-back frames**:
   - Stimulus: two frames with no idle bit between them (8'h3C then 8'hC3).
   - Required response: both received; `valid` pulses 100 ±1 cycles apart.
3. **Start glitch**:
   - Stimulus: `rx` low for 3 cycles, then high.
   - Required response: `busy` rises, then returns to 0 within `HALF_BIT`+3 cycles; no `valid`, no `frame_err`; `data` unchanged.
4. **Framing error and break**:
   - Stimulus: frame 8'h81 with stop bit 0, then `rx` held low for 50 bit times, then released high, then frame 8'h42.
   - Required response: exactly one `frame_err`; `data` still holds the previous value; the 8'h42 frame then produces `valid` with `data`=8'h42.
5. **Reset mid-frame**:
   - Stimulus: `rst_n` low for 2 cycles during bit 4 of a frame; line idles high afterwards.
   - Required response: all outputs go to their reset values; no pulse; the next frame 8'h99 is received correctly.
6. **Latency check**:
   - Stimulus: a single frame.
   - Required response: `valid` asserts exactly `HALF_BIT`+9·`CLKS_PER_BIT`+1 cycles after E (96 cycles at the test parameters).
